cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 34 +++
 rtl/onehot_decoder.sv | 15 +
 rtl/cache_fill_fsm.sv | 109 ++++++++++
 tb/tb_cache_fill_fsm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// cache_pkg: shared types and constants for the cache block fill controller.
//   state_t      : fill controller states (IDLE, FILL, TAG)
//   *_W          : address field widths (tag [15:10], index [9:4], offset [3:0])
//   WORDS        : 16-bit words per cache block
//   META_*       : bit positions inside the 8-bit metadata word
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int TAG_W      = 6;
    localparam int INDEX_W    = 6;
    localparam int OFFSET_W   = 4;
    localparam int WORDS      = 8;
    localparam int META_W     = 8;
    localparam int META_VALID = 7;
    localparam int META_LRU   = 6;

    // Freshly filled block: valid, not most-recently-used, tag in the low bits.
    function automatic logic [META_W-1:0] make_meta(input logic [TAG_W-1:0] tag);
        logic [META_W-1:0] m;
        m = '0;
        m[META_VALID] = 1'b1;
        m[META_LRU] = 1'b0;
        m[TAG_W-1:0] = tag;
        return m;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: N-bit binary select to 2^N one-hot, all zero when disabled.
//   sel    : binary select
//   en     : enable; onehot is all zero when low
//   onehot : one-hot decode of sel
module onehot_decoder #(
    parameter int N = 3
) (
    input  logic [N-1:0]        sel,
    input  logic                en,
    output logic [(1<<N)-1:0]   onehot
);

    assign onehot = en ? {{((1 << N) - 1){1'b0}}, 1'b1} << sel : '0;

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one cache block from memory after a miss, then writes its tag.
//   clk, rst          : clock, synchronous active-high reset
//   miss_detected     : miss request, held by the requester until fill_done
//   miss_address      : byte address of the miss
//   memory_data_valid : memory_data carries a returned word this cycle
//   memory_data       : returned memory word
//   fsm_busy          : fill in progress
//   mem_read          : read issue strobe, memory_address is the word address
//   set_enable        : one-hot set select to data and metadata arrays
//   word_enable       : one-hot word select to the data array
//   write_data_array  : data array write, data_out is the write data
//   write_tag_array   : metadata array write, meta_out is the write value
//   fill_done         : one-cycle fill-complete pulse
module cache_fill_fsm #(
    parameter int MEM_LATENCY = 4,
    parameter int WORDS       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_detected,
    input  logic [15:0]      miss_address,
    input  logic             memory_data_valid,
    input  logic [15:0]      memory_data,
    output logic             fsm_busy,
    output logic             mem_read,
    output logic [15:0]      memory_address,
    output logic [63:0]      set_enable,
    output logic [WORDS-1:0] word_enable,
    output logic             write_data_array,
    output logic [15:0]      data_out,
    output logic             write_tag_array,
    output logic [7:0]       meta_out,
    output logic             fill_done
);

    import cache_pkg::*;

    // Returned words are written strictly in order, so the return counter
    // alone selects the word; reads need one extra count to mark "all issued".
    localparam int RW = $clog2(WORDS);
    localparam int IW = $clog2(WORDS + 1);

    if (MEM_LATENCY < 1 || WORDS != (1 << RW)) begin : g_bad_params
        $error("cache_fill_fsm: MEM_LATENCY must be >= 1 and WORDS a power of two");
    end

    state_t state, state_n;
    logic [15:0] addr;
    logic [IW-1:0] issue_cnt;
    logic [RW-1:0] ret_cnt;
    logic [TAG_W-1:0] tag_f;
    logic [INDEX_W-1:0] index_f;
    logic issuing, writing, last_word, tagging;

    assign tag_f = addr[ADDR_W-1 -: TAG_W];
    assign index_f = addr[OFFSET_W +: INDEX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            issue_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && miss_detected)
                addr <= miss_address;
            issue_cnt <= (state == FILL) ? issue_cnt + IW'(issuing) : '0;
            ret_cnt <= (state == FILL) ? ret_cnt + RW'(writing) : '0;
        end
    end

    // Outputs are also gated by rst so an aborted fill drops every strobe
    // immediately rather than one cycle later.
    always_comb begin
        state_n = state;
        issuing = !rst && state == FILL && int'(issue_cnt) < WORDS;
        writing = !rst && state == FILL && memory_data_valid;
        tagging = !rst && state == TAG;
        last_word = writing && int'(ret_cnt) == WORDS - 1;
        case (state)
            IDLE: state_n = miss_detected ? FILL : IDLE;
            FILL: state_n = last_word ? TAG : FILL;
            TAG: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        fsm_busy = !rst && state != IDLE;
        mem_read = issuing;
        memory_address = issuing ? {tag_f, index_f, {OFFSET_W{1'b0}}} + 16'({issue_cnt, 1'b0}) : '0;
        write_data_array = writing;
        data_out = writing ? memory_data : '0;
        write_tag_array = tagging;
        meta_out = tagging ? make_meta(tag_f) : '0;
        fill_done = tagging;
    end

    onehot_decoder #(.N(INDEX_W)) u_set_dec (
        .sel(index_f),
        .en(writing || tagging),
        .onehot(set_enable)
    );

    onehot_decoder #(.N(RW)) u_word_dec (
        .sel(ret_cnt),
        .en(writing),
        .onehot(word_enable)
    );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed self-checking bench for cache_fill_fsm with a
// fixed-latency memory model and behavioural data/metadata arrays.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic miss_detected;
    logic [15:0] miss_address;
    logic memory_data_valid;
    logic [15:0] memory_data;
    logic fsm_busy, mem_read, write_data_array, write_tag_array, fill_done;
    logic [15:0] memory_address, data_out;
    logic [63:0] set_enable;
    logic [7:0] word_enable, meta_out;

    logic inj_v;
    logic [15:0] inj_d;
    logic [16:0] pipe [LAT] = '{default: '0};
    logic [15:0] data_arr [64][8] = '{default: '{default: '0}};
    logic [7:0] meta_arr [64] = '{default: '0};
    int data_writes = 0;
    int tag_writes = 0;
    int checks = 0;
    int errors = 0;
    int dw;

    cache_fill_fsm #(.MEM_LATENCY(LAT), .WORDS(8)) dut (
        .clk(clk),
        .rst(rst),
        .miss_detected(miss_detected),
        .miss_address(miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data(memory_data),
        .fsm_busy(fsm_busy),
        .mem_read(mem_read),
        .memory_address(memory_address),
        .set_enable(set_enable),
        .word_enable(word_enable),
        .write_data_array(write_data_array),
        .data_out(data_out),
        .write_tag_array(write_tag_array),
        .meta_out(meta_out),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    // Memory: each issue returns 0xA000 + word number LAT cycles later.
    // Not reset, so reads issued before a reset still come back afterwards.
    always @(posedge clk) begin
        pipe[0] <= {mem_read, memory_address};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign memory_data_valid = pipe[LAT-1][16] | inj_v;
    assign memory_data = inj_v ? inj_d : 16'hA000 + 16'(pipe[LAT-1][3:1]);

    function automatic int onehot_idx(input logic [63:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 64; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        if (write_data_array) begin
            data_arr[onehot_idx(set_enable)][onehot_idx(64'(word_enable)) % 8] <= data_out;
            data_writes <= data_writes + 1;
        end
        if (write_tag_array) begin
            meta_arr[onehot_idx(set_enable)] <= meta_out;
            tag_writes <= tag_writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = '0;
        inj_v = 1'b0;
        inj_d = '0;
        tick();
        tick();
        chk("rst_busy", fsm_busy, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_set", set_enable, 0);
        chk("rst_word", word_enable, 0);
        chk("rst_wr", write_data_array, 0);
        chk("rst_tagwr", write_tag_array, 0);
        chk("rst_done", fill_done, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", fsm_busy, 0);

        // Fill of 0x1A36: tag 6, set 35; address disturbed mid-fill.
        miss_detected = 1'b1;
        miss_address = 16'h1A36;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk($sformatf("f1_busy_c%0d", c), fsm_busy, 64'(c <= 13));
            chk($sformatf("f1_rd_c%0d", c), mem_read, 64'(c <= 8));
            if (c <= 8) chk($sformatf("f1_addr_c%0d", c), memory_address, 64'(16'h1A30 + 2 * (c - 1)));
            chk($sformatf("f1_wr_c%0d", c), write_data_array, 64'(c >= 5 && c <= 12));
            chk($sformatf("f1_set_c%0d", c), set_enable, (c >= 5 && c <= 13) ? 64'd1 << 35 : 64'd0);
            chk($sformatf("f1_word_c%0d", c), word_enable, (c >= 5 && c <= 12) ? 64'd1 << (c - 5) : 64'd0);
            if (c >= 5 && c <= 12) chk($sformatf("f1_dout_c%0d", c), data_out, 64'(16'hA000 + c - 5));
            chk($sformatf("f1_tagwr_c%0d", c), write_tag_array, 64'(c == 13));
            chk($sformatf("f1_done_c%0d", c), fill_done, 64'(c == 13));
            if (c == 13) chk("f1_meta", meta_out, 8'h86);
            if (c == 2) begin miss_address = 16'hFFF0; miss_detected = 1'b0; end
            if (c == 3) begin miss_address = 16'h1A36; miss_detected = 1'b1; end
            if (c == 13) miss_detected = 1'b0;
        end
        for (int k = 0; k < 8; k++) chk($sformatf("f1_arr_w%0d", k), data_arr[35][k], 64'(16'hA000 + k));
        chk("f1_meta_arr", meta_arr[35], 8'h86);
        chk("f1_meta_ffff", meta_arr[63], 0);
        chk("f1_nwrites", data_writes, 8);
        chk("f1_ntags", tag_writes, 1);

        // Reset during cycle 7 of a fill of 0x0420 (tag 1, set 2).
        miss_detected = 1'b1;
        miss_address = 16'h0420;
        for (int c = 1; c <= 6; c++) tick();
        rst = 1'b1;
        miss_detected = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("ab_busy", fsm_busy, 0);
        chk("ab_rd", mem_read, 0);
        chk("ab_set", set_enable, 0);
        chk("ab_word", word_enable, 0);
        chk("ab_tagwr", write_tag_array, 0);
        chk("ab_done", fill_done, 0);
        dw = data_writes;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("ab_wr_%0d", c), write_data_array, 0);
            chk($sformatf("ab_tw_%0d", c), write_tag_array, 0);
            tick();
        end
        chk("ab_nwrites", data_writes, 64'(dw));
        chk("ab_meta2", meta_arr[2], 0);
        chk("ab_ntags", tag_writes, 1);

        // Valid data while idle must not write.
        inj_v = 1'b1;
        inj_d = 16'h5A5A;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("id_wr_%0d", c), write_data_array, 0);
            chk($sformatf("id_set_%0d", c), set_enable, 0);
            chk($sformatf("id_word_%0d", c), word_enable, 0);
        end
        inj_v = 1'b0;
        tick();
        chk("id_nwrites", data_writes, 64'(dw));
        chk("id_arr", data_arr[35][0], 16'hA000);

        // Back-to-back: 0x0000 then 0xFC10 (tag 0x3F, set 1), miss held throughout.
        miss_detected = 1'b1;
        miss_address = 16'h0000;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c == 1) chk("bb_rd1", mem_read, 1);
            if (c == 1) chk("bb_addr1", memory_address, 16'h0000);
            if (c == 13) chk("bb_meta1", meta_out, 8'h80);
            if (c == 13) chk("bb_done1", fill_done, 1);
            if (c == 14) chk("bb_idle", fsm_busy, 0);
            if (c == 14) chk("bb_rd14", mem_read, 0);
            if (c == 15) chk("bb_busy15", fsm_busy, 1);
            if (c == 15) chk("bb_rd15", mem_read, 1);
            if (c == 15) chk("bb_addr15", memory_address, 16'hFC10);
            if (c == 22) chk("bb_addr22", memory_address, 16'hFC1E);
            if (c == 19) chk("bb_word19", word_enable, 1);
            if (c == 19) chk("bb_set19", set_enable, 64'd2);
            if (c == 27) chk("bb_meta2", meta_out, 8'hBF);
            if (c == 27) chk("bb_set27", set_enable, 64'd2);
            if (c == 27) chk("bb_done2", fill_done, 1);
            if (c == 28) chk("bb_end", fsm_busy, 0);
            if (c == 13) miss_address = 16'hFC10;
            if (c == 27) miss_detected = 1'b0;
        end
        chk("bb_meta_arr0", meta_arr[0], 8'h80);
        chk("bb_meta_arr1", meta_arr[1], 8'hBF);
        chk("bb_arr1_w7", data_arr[1][7], 16'hA007);
        chk("bb_ntags", tag_writes, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
